// File: rtl/matmul_seq_ctrl_if.sv
// Operand/result handshake bundle for matmul_seq_ctrl: operands in on in_valid/in_ready, product out on out_valid/out_ready.
// No logic here; latency is set entirely by the attached controller.
// master drives operands and out_ready, slave (the controller) drives in_ready, out_valid, Res and busy.
interface matmul_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int NOS   = 4
);
  logic                               in_valid;
  logic                               in_ready;
  logic [NOS-1:0][NOS-1:0][WIDTH-1:0] A_in;
  logic [NOS-1:0][NOS-1:0][WIDTH-1:0] B_in;
  logic                               out_valid;
  logic                               out_ready;
  logic [NOS-1:0][NOS-1:0][WIDTH-1:0] Res;
  logic                               busy;

  modport master (
    output in_valid, A_in, B_in, out_ready,
    input  in_ready, out_valid, Res, busy
  );

  modport slave (
    input  in_valid, A_in, B_in, out_ready,
    output in_ready, out_valid, Res, busy
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequenced NOS x NOS signed matrix multiply sharing one multiplier and one accumulator; macro MATMUL_ACC_SAT_EN selects saturating writeback.
// Latency: out_valid rises exactly NOS^3 cycles after the accept edge, one (i,j,k) term per cycle.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no same-cycle re-accept.
module matmul_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int NOS   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  matmul_seq_ctrl_if.slave bus
);

  localparam int CW = (NOS > 1) ? $clog2(NOS) : 1;
`ifdef MATMUL_ACC_SAT_EN
  // Full-precision accumulator: NOS products of 2*WIDTH bits never overflow.
  localparam int AW = 2 * WIDTH + CW;
  localparam int PW = 2 * WIDTH;
  localparam logic signed [AW-1:0] SMAX = {{(AW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
`else
  // Wrap build only needs the low WIDTH bits of every product and of the sum.
  localparam int AW = WIDTH;
  localparam int PW = WIDTH;
`endif

  localparam logic [CW-1:0] LAST = CW'(NOS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef logic [NOS-1:0][NOS-1:0][WIDTH-1:0] mat_t;

  logic [1:0]              state;
  logic [CW-1:0]           i, j, k;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    acc_base;
  logic signed [AW-1:0]    acc_next;
  logic signed [WIDTH-1:0] a_op;
  logic signed [WIDTH-1:0] b_op;
  logic signed [PW-1:0]    prod;
  logic [WIDTH-1:0]        wb;
  mat_t                    a_r, b_r, res_r;
  logic                    out_valid_r;
  logic                    busy_r;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.Res       = res_r;

  // Datapath for the current term: select operands, multiply, accumulate, form the writeback value.
  always_comb begin
    a_op     = a_r[i][k];
    b_op     = b_r[k][j];
    prod     = PW'(a_op) * PW'(b_op);
    acc_base = (k == '0) ? '0 : acc;
    acc_next = acc_base + AW'(prod);
    wb       = acc_next[WIDTH-1:0];
`ifdef MATMUL_ACC_SAT_EN
    if (acc_next > SMAX) begin
      wb = SMAX[WIDTH-1:0];
    end else if (acc_next < SMIN) begin
      wb = SMIN[WIDTH-1:0];
    end
`endif
  end

  // Control FSM, loop counters (k innermost, then j, then i) and result register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      acc         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r    <= bus.A_in;
            b_r    <= bus.B_in;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            acc    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (k == LAST) begin
            res_r[i][j] <= wb;
            k           <= '0;
            if (j == LAST) begin
              j <= '0;
              if (i == LAST) begin
                i           <= '0;
                busy_r      <= 1'b0;
                out_valid_r <= 1'b1;
                state       <= DONE;
              end else begin
                i <= i + CW'(1);
              end
            end else begin
              j <= j + CW'(1);
            end
          end else begin
            k <= k + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
